// File: rtl/wb_imc_slave.sv
// Wishbone classic slave front-end for the IMC buffer controller: turns cyc/stb/ack
// cycles into single-cycle buffer write strobes, timed buffer reads and a flag status word.
module wb_imc_slave #(
    parameter int                   WIDTH_WB_DATA = 32,
    parameter int                   WIDTH_ADD     = 32,
    parameter int                   RD_LAT        = 2,
    parameter logic [7:0]           STATUS_SEL    = 8'hFF,
    parameter logic [WIDTH_ADD-1:0] IDLE_ADDR     = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [WIDTH_ADD-1:0]     wbs_adr_i,
    input  logic [WIDTH_WB_DATA-1:0] wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [WIDTH_WB_DATA-1:0] wbs_dat_o,
    output logic                     buf_we,
    output logic [WIDTH_ADD-1:0]     buf_addr,
    output logic [WIDTH_WB_DATA-1:0] buf_wdata,
    input  logic [WIDTH_WB_DATA-1:0] buf_rdata,
    input  logic [7:0]               flags
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t                   state, state_nxt;
    logic [WIDTH_ADD-1:0]     adr_q, adr_d;
    logic [WIDTH_WB_DATA-1:0] dat_q, dat_d;
    logic [WIDTH_WB_DATA-1:0] rdat_q, rdat_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     is_status;
    logic                     sel_unused;

    // Byte selects carry no meaning here: only full-word accesses exist.
    assign sel_unused = ^wbs_sel_i;
    assign is_status  = (wbs_adr_i[WIDTH_ADD-1 -: 8] == STATUS_SEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            adr_q  <= IDLE_ADDR;
            dat_q  <= '0;
            rdat_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            rdat_q <= rdat_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read data only lives for the ACK cycle; every other cycle clears it.
    always_comb begin
        state_nxt = state;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cnt_d     = cnt_q;
        rdat_d    = '0;
        case (state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d = wbs_adr_i;
                    dat_d = wbs_dat_i;
                    if (wbs_we_i) begin
                        state_nxt = is_status ? S_ACK : S_WR;
                    end else if (is_status) begin
                        rdat_d    = {{(WIDTH_WB_DATA-8){1'b0}}, flags};
                        state_nxt = S_ACK;
                    end else begin
                        cnt_d     = LAT_LOAD;
                        state_nxt = S_RD;
                    end
                end
            end
            S_WR: begin
                state_nxt = S_ACK;
            end
            S_RD: begin
                if (!wbs_cyc_i) begin
                    cnt_d     = '0;
                    state_nxt = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    rdat_d    = buf_rdata;
                    state_nxt = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A write is committed once WR is reached; a dropped cycle only hides the ack.
    assign buf_we    = (state == S_WR);
    assign buf_addr  = (state == S_WR || state == S_RD) ? adr_q : IDLE_ADDR;
    assign buf_wdata = dat_q;
    assign wbs_ack_o = (state == S_ACK) && wbs_cyc_i;
    assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_imc_slave.sv
// Self-checking bench for wb_imc_slave: a vector table of single transactions scored
// through an expectation queue, plus hand-written reset, abort and back-to-back sequences.
module tb_wb_imc_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        buf_we;
    logic [31:0] buf_addr, buf_wdata, buf_rdata;
    logic [7:0]  flags;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic [7:0]  flg;
        logic [31:0] exp_dat;
        int          exp_lat;
        int          exp_we;
        int          exp_addr_cycles;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   vectors     = 0;
    int   miscompares = 0;

    wb_imc_slave #(
        .WIDTH_WB_DATA(32),
        .WIDTH_ADD    (32),
        .RD_LAT       (2),
        .STATUS_SEL   (8'hFF),
        .IDLE_ADDR    (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleBus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
    endtask

    task automatic driveReq(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = 4'hF;
    endtask

    // Cycle n is sampled 1 time unit after the n-th rising edge following the request.
    task automatic applyStimulus(input vec_t v);
        int          we_cnt   = 0;
        int          addr_cnt = 0;
        int          ack_n    = 0;
        logic [31:0] dat_seen = '0;
        exp_t        e;
        flags     = v.flg;
        buf_rdata = v.rdata;
        driveReq(v.we, v.adr, v.dat);
        exp_q.push_back('{dat: v.exp_dat, lat: v.exp_lat});
        for (int n = 1; n <= 20 && ack_n == 0; n++) begin
            @(posedge clk); #1;
            if (buf_we) begin
                we_cnt++;
                checkOutput("wr_addr", buf_addr, v.adr);
                checkOutput("wr_data", buf_wdata, v.dat);
            end
            if (buf_addr != 32'h0) addr_cnt++;
            if (wbs_ack_o) begin
                ack_n    = n;
                dat_seen = wbs_dat_o;
                idleBus();
            end
        end
        e = exp_q.pop_front();
        if (ack_n == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ack_timeout: no ack within 20 cycles, expected ack at cycle %0d", e.lat);
            idleBus();
        end else begin
            checkOutput("ack_latency", ack_n, e.lat);
            checkOutput("ack_data", dat_seen, e.dat);
        end
        checkOutput("we_pulses", we_cnt, v.exp_we);
        checkOutput("addr_cycles", addr_cnt, v.exp_addr_cycles);
        @(posedge clk); #1;
        checkOutput("post_addr", buf_addr, 32'h0);
        checkOutput("post_dat", wbs_dat_o, 32'h0);
        checkOutput("post_ack", {31'b0, wbs_ack_o}, 32'h0);
    endtask

    task automatic resetMidRead();
        buf_rdata = 32'h1111_2222;
        driveReq(1'b0, 32'h0408_0002, 32'h0);
        @(posedge clk); #1;
        checkOutput("rd_addr_before_rst", buf_addr, 32'h0408_0002);
        reset = 1'b1;
        #1;
        checkOutput("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
        checkOutput("rst_addr", buf_addr, 32'h0);
        checkOutput("rst_we", {31'b0, buf_we}, 32'h0);
        idleBus();
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_hold_addr", buf_addr, 32'h0);
    endtask

    task automatic backToBackWrites();
        int we_n[$];
        int ack_n[$];
        driveReq(1'b1, 32'h0100_0010, 32'hCAFE_0001);
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (buf_we) begin
                we_n.push_back(n);
                checkOutput("b2b_addr", buf_addr, (we_n.size() == 1) ? 32'h0100_0010 : 32'h0100_0020);
                checkOutput("b2b_data", buf_wdata, (we_n.size() == 1) ? 32'hCAFE_0001 : 32'hCAFE_0002);
            end
            if (wbs_ack_o) begin
                ack_n.push_back(n);
                if (ack_n.size() == 1) begin
                    wbs_adr_i = 32'h0100_0020;
                    wbs_dat_i = 32'hCAFE_0002;
                end else begin
                    idleBus();
                end
            end
        end
        checkOutput("b2b_we_count", we_n.size(), 32'd2);
        checkOutput("b2b_ack_count", ack_n.size(), 32'd2);
        if (ack_n.size() == 2 && we_n.size() == 2) begin
            checkOutput("b2b_ack_spacing", ack_n[1] - ack_n[0], 32'd3);
            checkOutput("b2b_we_spacing", we_n[1] - we_n[0], 32'd3);
        end
    endtask

    task automatic abortRead();
        int ack_cnt = 0;
        int we_cnt  = 0;
        buf_rdata = 32'h5555_AAAA;
        driveReq(1'b0, 32'h0200_0001, 32'h0);
        @(posedge clk); #1;
        checkOutput("abort_rd_addr", buf_addr, 32'h0200_0001);
        idleBus();
        @(posedge clk); #1;
        checkOutput("abort_addr_idle", buf_addr, 32'h0);
        for (int n = 0; n < 5; n++) begin
            if (wbs_ack_o) ack_cnt++;
            if (buf_we) we_cnt++;
            @(posedge clk); #1;
        end
        checkOutput("abort_acks", ack_cnt, 32'd0);
        checkOutput("abort_we", we_cnt, 32'd0);
        checkOutput("abort_dat", wbs_dat_o, 32'h0);
    endtask

    task automatic writeCycDropped();
        driveReq(1'b1, 32'h0300_0004, 32'h0000_1234);
        @(posedge clk); #1;
        checkOutput("wdrop_we", {31'b0, buf_we}, 32'h1);
        checkOutput("wdrop_addr", buf_addr, 32'h0300_0004);
        idleBus();
        @(posedge clk); #1;
        checkOutput("wdrop_ack", {31'b0, wbs_ack_o}, 32'h0);
        checkOutput("wdrop_we_after", {31'b0, buf_we}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0100_0003, 32'h0000_BEEF, 32'h0,         8'h00,        32'h0,         2, 1, 1};
        vecs[1] = '{1'b0, 32'h0408_0002, 32'h0,         32'h1234_5678, 8'h00,        32'h1234_5678, 3, 0, 2};
        vecs[2] = '{1'b0, 32'hFF00_0000, 32'h0,         32'hFFFF_FFFF, 8'b1000_0111, 32'h0000_0087, 1, 0, 0};
        vecs[3] = '{1'b1, 32'hFF00_0010, 32'h1357_9BDF, 32'h0,         8'h33,        32'h0,         1, 0, 0};
        vecs[4] = '{1'b1, 32'hFE12_3456, 32'hAAAA_5555, 32'h0,         8'h00,        32'h0,         2, 1, 1};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 8'hFF,        32'hDEAD_BEEF, 3, 0, 2};
        vecs[6] = '{1'b0, 32'hFF12_3456, 32'h0,         32'h0BAD_F00D, 8'h5A,        32'h0000_005A, 1, 0, 0};

        reset     = 1'b1;
        flags     = '0;
        buf_rdata = '0;
        wbs_sel_i = 4'hF;
        idleBus();
        #1;
        checkOutput("reset_ack", {31'b0, wbs_ack_o}, 32'h0);
        checkOutput("reset_addr", buf_addr, 32'h0);
        checkOutput("reset_we", {31'b0, buf_we}, 32'h0);
        checkOutput("reset_dat", wbs_dat_o, 32'h0);
        checkOutput("reset_wdata", buf_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        resetMidRead();
        applyStimulus(vecs[1]);

        // stb with cyc low must not start anything
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h0100_0003;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("stb_no_cyc_we", {31'b0, buf_we}, 32'h0);
            checkOutput("stb_no_cyc_addr", buf_addr, 32'h0);
        end
        idleBus();
        @(posedge clk); #1;

        backToBackWrites();
        @(posedge clk); #1;
        abortRead();
        writeCycDropped();
        applyStimulus(vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_imc_slave.md
Name: wb_imc_slave

Overview:
Wishbone classic slave front-end that sits directly upstream of the IMC buffer/controller top level. It converts multi-cycle Wishbone cycles (cyc/stb/ack) into the single-cycle write strobe, address and data that the buffer decoder expects, waits out buffer read latency and returns read data with ack. It also exposes the eight buffer full/empty flags as a read-only status word.

Parameters:
WIDTH_WB_DATA, 32, Wishbone data width.
WIDTH_ADD, 32, Wishbone address width.
RD_LAT, 2, cycles buf_addr is held before buf_rdata is sampled (1..7).
STATUS_SEL, 8'hFF, value of adr[31:24] selecting the status word.
IDLE_ADDR, 32'h0000_0000, value driven on buf_addr when no access is in progress (decodes to no buffer).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  1 = write, 0 = read.
wbs_sel_i  in  4  byte selects; ignored, full-word access only.
wbs_adr_i  in  WIDTH_ADD  Wishbone address.
wbs_dat_i  in  WIDTH_WB_DATA  write data.
wbs_ack_o  out  1  one-cycle acknowledge.
wbs_dat_o  out  WIDTH_WB_DATA  read data, valid while ack=1.
buf_we  out  1  write strobe to buffer decoder; high exactly one cycle per write.
buf_addr  out  WIDTH_ADD  address to buffer decoder/mux.
buf_wdata  out  WIDTH_WB_DATA  write data to buffers.
buf_rdata  in  WIDTH_WB_DATA  muxed read data from SA/OB buffers.
flags  in  8  {full_IB, full_WB, full_SA, full_OB, empty_IB, empty_WB, empty_SA, empty_OB}.

Behaviour:
- Reset (asserted at any time, immediately): state=IDLE, wbs_ack_o=0, wbs_dat_o=0, buf_we=0, buf_addr=IDLE_ADDR, buf_wdata=0, read-latency counter=0.
- States: IDLE, WR, RD, ACK.
- IDLE: on cyc&stb, register adr/dat/we. Transitions:
  - we=1 and adr[31:24]!=STATUS_SEL -> WR.
  - we=1 and adr[31:24]==STATUS_SEL -> ACK; write dropped, buf_we stays 0.
  - we=0 and adr[31:24]==STATUS_SEL -> ACK with wbs_dat_o={24'b0, flags} sampled in the IDLE cycle.
  - we=0 otherwise -> RD; counter loads RD_LAT-1.
- WR (1 cycle): buf_we=1, buf_addr=registered adr, buf_wdata=registered dat -> ACK. Write ack is therefore 2 cycles after the request is sampled.
- RD: buf_addr=registered adr, buf_we=0. Counter decrements each cycle. When counter==0, capture buf_rdata into wbs_dat_o -> ACK. Read ack is RD_LAT+1 cycles after the request is sampled.
- ACK (1 cycle): wbs_ack_o=1, buf_addr=IDLE_ADDR, buf_we=0 -> IDLE. wbs_dat_o returns to 0 on the next cycle. A new request cannot be accepted in the ACK cycle, so back-to-back accesses take 1 idle cycle between acks.
- buf_addr equals IDLE_ADDR in every cycle outside WR/RD. buf_we is never high outside WR, so each Wishbone write produces exactly one buffer write.
- Abort: if cyc falls while in RD, go to IDLE, no ack, buf_addr=IDLE_ADDR. WR always completes (the write is committed); ack is suppressed if cyc=0 in the ACK cycle.
- stb asserted with cyc=0 is ignored. Request inputs are not re-sampled outside IDLE.
- wbs_dat_o is 0 for writes.

Test Plan:
- Reset mid-read (reset high during RD) -> next edge: ack=0, buf_addr=0, state IDLE; a following access behaves normally.
- Write adr=0x0100_0003, dat=0x0000_BEEF -> buf_we=1 for exactly one cycle, with buf_addr=0x0100_0003 and buf_wdata=0x0000_BEEF; ack 2 cycles after sampling; buf_addr=0 afterwards.
- Read adr=0x0408_0002 with RD_LAT=2 and buf_rdata=0x1234_5678 -> buf_addr held 2 cycles; ack at cycle 3 with wbs_dat_o=0x1234_5678; buf_we=0 throughout.
- Status read adr=0xFF00_0000 with flags=8'b1000_0111 -> ack 1 cycle after sampling, wbs_dat_o=0x0000_0087; buf_addr stays 0. Status write -> ack, buf_we=0.
- Two back-to-back writes with stb held -> two separate single-cycle buf_we pulses and two acks, with one idle cycle between acks.
- Read with cyc dropped in the first RD cycle -> no ack, buf_addr returns to 0 next cycle, no buf_we.
